// File: rtl/uart_baud_gen_pkg.sv
// Package uart_pkg: shared types and constants for the UART bit-timing generator.
//   state_e    - generator FSM states (IDLE, RUN, HOLD)
//   MIN_DIV    - smallest legal clocks-per-bit; keeps bit_mid and bit_end on distinct cycles
//   DEF_*      - reset-time clock/baud defaults (DEF_DIV = 5208 clocks per bit)
//   clamp_div  - raises a requested divisor to MIN_DIV
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam int unsigned MIN_DIV      = 4;
  localparam int unsigned DEF_CLK_FREQ = 50_000_000;
  localparam int unsigned DEF_BAUD     = 9600;
  localparam int unsigned DEF_DIV      = DEF_CLK_FREQ / DEF_BAUD;

  function automatic int unsigned clamp_div(input int unsigned div);
    return (div < MIN_DIV) ? MIN_DIV : div;
  endfunction

endpackage

// File: rtl/uart_baud_gen_if.sv
// Interface uart_baud_gen_if: control and strobe bundle between a UART TX/RX controller
// (master) and the bit-timing generator (slave).
//   run, div_load, baud_div          - controller -> generator
//   div_err, busy, bit_mid, bit_end,
//   bit_idx, frame_done, os_tick     - generator -> controller / shift register
interface uart_baud_gen_if #(
  parameter int unsigned DIV_W = 16
) ();

  logic             run;
  logic             div_load;
  logic [DIV_W-1:0] baud_div;
  logic             div_err;
  logic             busy;
  logic             bit_mid;
  logic             bit_end;
  logic [3:0]       bit_idx;
  logic             frame_done;
  logic             os_tick;

  modport master (
    output run, div_load, baud_div,
    input  div_err, busy, bit_mid, bit_end, bit_idx, frame_done, os_tick
  );

  modport slave (
    input  run, div_load, baud_div,
    output div_err, busy, bit_mid, bit_end, bit_idx, frame_done, os_tick
  );

endinterface

// File: rtl/uart_os_tick.sv
// Module uart_os_tick: oversample strobe counter for the UART bit-timing generator.
// Only instantiated when UART_BAUD_OS_EN is defined.
//   clk_i, rst_ni - clock, asynchronous active-low reset
//   en_i          - generator is timing a bit (os_tick_o gated by this)
//   restart_i     - counter is forced to 0 on the next cycle (bit start / not running)
//   os_div_i      - clocks per oversample tick (>= 1)
//   os_tick_o     - one-cycle pulse when the counter reaches os_div_i-1
module uart_os_tick #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic         restart_i,
  input  logic [W-1:0] os_div_i,
  output logic         os_tick_o
);

  logic [W-1:0] os_cnt_q, os_cnt_d;
  logic         at_end;

  assign at_end = (os_cnt_q == os_div_i - W'(1));

  always_comb begin
    os_cnt_d = os_cnt_q + W'(1);
    if (restart_i || at_end) begin
      os_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      os_cnt_q <= '0;
    end else begin
      os_cnt_q <= os_cnt_d;
    end
  end

  assign os_tick_o = en_i && at_end;

endmodule

// File: rtl/uart_baud_gen.sv
// Module uart_baud_gen: runtime-programmable UART bit-timing generator.
// Times one frame of FRAME_BITS bits per run request, emitting a mid-bit sample strobe,
// an end-of-bit strobe, the current bit index and a frame_done pulse on the last bit_end.
// Optional feature macro: UART_BAUD_OS_EN (adds the oversample counter driving os_tick).
//   CLK  - system clock, rising edge
//   RSTn - asynchronous reset, active low
//   bus  - uart_baud_gen_if slave modport (run/div_load/baud_div in; strobes and status out)
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = DEF_CLK_FREQ,
  parameter int unsigned BAUD       = DEF_BAUD,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned FRAME_BITS = 10,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic           CLK,
  input  logic           RSTn,
  uart_baud_gen_if.slave bus
);

  localparam int unsigned      DefDiv  = CLK_FREQ / BAUD;
  localparam logic [DIV_W-1:0] DefDivW = DIV_W'(DefDiv);
  localparam logic [3:0]       LastIdx = 4'(FRAME_BITS - 1);

  if (FRAME_BITS < 2 || FRAME_BITS > 16 || OVERSAMPLE == 0 || (DefDiv >> DIV_W) != 0)
  begin : g_bad_param
    $error("uart_baud_gen: illegal parameter combination");
  end

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [3:0]       idx_q, idx_d;
  logic             mid_q, mid_d;
  logic             end_q, end_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             bit_last;

  assign bit_last = (cnt_q == div_q - DIV_W'(1));

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        // A load in the same cycle as run takes effect for the frame being started.
        if (bus.div_load) begin
          div_d = DIV_W'(clamp_div(32'(bus.baud_div)));
        end
        if (bus.run) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!bus.run) begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end else if (bit_last) begin
          cnt_d = '0;
          if (idx_q == LastIdx) begin
            idx_d   = '0;
            state_d = HOLD;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      HOLD: begin
        cnt_d = '0;
        idx_d = '0;
        // Re-arming requires run to drop first, so one run level never times two frames.
        if (!bus.run) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase

    // Strobes are registered from next-state values so they line up with cnt_q/bit_idx.
    mid_d  = (state_d == RUN) && (cnt_d == (div_d >> 1));
    end_d  = (state_d == RUN) && (cnt_d == div_d - DIV_W'(1));
    done_d = end_d && (idx_d == LastIdx);
    err_d  = bus.div_load && (state_q != IDLE);
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= IDLE;
      div_q   <= DefDivW;
      cnt_q   <= '0;
      idx_q   <= '0;
      mid_q   <= 1'b0;
      end_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      mid_q   <= mid_d;
      end_q   <= end_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.bit_mid    = mid_q;
  assign bus.bit_end    = end_q;
  assign bus.bit_idx    = idx_q;
  assign bus.frame_done = done_q;
  assign bus.div_err    = err_q;

`ifdef UART_BAUD_OS_EN
  logic [DIV_W-1:0] os_div;
  logic             os_restart;
  logic             os_tick;

  always_comb begin
    os_div = div_q / DIV_W'(OVERSAMPLE);
    if (os_div == '0) begin
      os_div = DIV_W'(1);
    end
  end

  // Realign the oversample phase whenever the next cycle starts a bit or leaves RUN.
  assign os_restart = (state_d != RUN) || (cnt_d == '0);

  uart_os_tick #(
    .W (DIV_W)
  ) u_os_tick (
    .clk_i     (CLK),
    .rst_ni    (RSTn),
    .en_i      (state_q == RUN),
    .restart_i (os_restart),
    .os_div_i  (os_div),
    .os_tick_o (os_tick)
  );

  assign bus.os_tick = os_tick;
`else
  assign bus.os_tick = 1'b0;
`endif

endmodule

// File: tb/tb_uart_baud_gen.sv
// Directed testbench for uart_baud_gen (default 50 MHz / 9600 bps, 10-bit frames).
module tb_uart_baud_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  uart_baud_gen_if #(.DIV_W(16)) bus ();

  uart_baud_gen #(
    .CLK_FREQ   (50_000_000),
    .BAUD       (9600),
    .DIV_W      (16),
    .FRAME_BITS (10),
    .OVERSAMPLE (16)
  ) dut (
    .CLK  (clk),
    .RSTn (rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Observation results, k = cycles since the first negedge after run was driven high.
  int mid_cnt, end_cnt, fd_cnt, err_cnt, os_cnt, both_cnt;
  int first_mid, first_end, fd_pos, err_pos, last_strobe, idle_pos, drop_idx;
  int min_sp, max_sp, prev_end;
  int os_first, os_min, os_max, os_prev;
  int idx_at_end[16];
  logic busy_end;
  logic [3:0] idx_end;

  // Samples outputs on each negedge for n cycles; optionally drops run or injects a load.
  task automatic observe(input int n, input int drop_at, input int inject_at);
    mid_cnt = 0; end_cnt = 0; fd_cnt = 0; err_cnt = 0; os_cnt = 0; both_cnt = 0;
    first_mid = -1; first_end = -1; fd_pos = -1; err_pos = -1; last_strobe = -1;
    idle_pos = -1; drop_idx = -1;
    min_sp = 1 << 30; max_sp = 0; prev_end = -1;
    os_first = -1; os_min = 1 << 30; os_max = 0; os_prev = -1;
    for (int j = 0; j < 16; j++) idx_at_end[j] = -1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) bus.div_load = 1'b0;
      if (inject_at >= 0 && i == inject_at + 1) bus.div_load = 1'b0;
      if (bus.bit_mid === 1'b1) begin
        mid_cnt++;
        if (first_mid < 0) first_mid = i;
        last_strobe = i;
      end
      if (bus.bit_end === 1'b1) begin
        if (end_cnt < 16) idx_at_end[end_cnt] = int'(bus.bit_idx);
        end_cnt++;
        if (first_end < 0) first_end = i;
        if (prev_end >= 0) begin
          if (i - prev_end < min_sp) min_sp = i - prev_end;
          if (i - prev_end > max_sp) max_sp = i - prev_end;
        end
        prev_end = i;
        last_strobe = i;
      end
      if (bus.bit_mid === 1'b1 && bus.bit_end === 1'b1) both_cnt++;
      if (bus.frame_done === 1'b1) begin
        fd_cnt++;
        fd_pos = i;
        last_strobe = i;
      end
      if (bus.div_err === 1'b1) begin
        err_cnt++;
        err_pos = i;
      end
      if (bus.os_tick === 1'b1) begin
        os_cnt++;
        if (os_first < 0) os_first = i;
        if (os_prev >= 0) begin
          if (i - os_prev < os_min) os_min = i - os_prev;
          if (i - os_prev > os_max) os_max = i - os_prev;
        end
        os_prev = i;
      end
      if (bus.busy === 1'b0 && idle_pos < 0) idle_pos = i;
      if (i == drop_at) begin
        drop_idx = int'(bus.bit_idx);
        bus.run = 1'b0;
      end
      if (i == inject_at) begin
        bus.div_load = 1'b1;
        bus.baud_div = 16'd100;
      end
    end
    busy_end = bus.busy;
    idx_end  = bus.bit_idx;
  endtask

  task automatic load_div(input int v);
    bus.div_load = 1'b1;
    bus.baud_div = 16'(v);
    @(negedge clk);
    bus.div_load = 1'b0;
  endtask

  task automatic go_idle();
    bus.run = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.run = 1'b0;
    bus.div_load = 1'b0;
    bus.baud_div = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.bit_mid, bus.bit_end, bus.frame_done, bus.div_err, bus.os_tick} !== 6'b0)
    begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 000000",
               {bus.busy, bus.bit_mid, bus.bit_end, bus.frame_done, bus.div_err, bus.os_tick});
    end
    n_checks++;
    if (bus.bit_idx !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_bit_idx: got %0d expected 0", bus.bit_idx);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_busy: got %b expected 0", bus.busy);
    end
  endtask

  task automatic test_default_frame();
    bus.run = 1'b1;
    observe(52100, -1, -1);
    n_checks++;
    if (first_mid !== 2604) begin
      n_fail++;
      $display("FAIL def_first_mid: got %0d expected 2604", first_mid);
    end
    n_checks++;
    if (first_end !== 5207 || min_sp !== 5208 || max_sp !== 5208) begin
      n_fail++;
      $display("FAIL def_bit_period: first_end %0d sp %0d..%0d expected 5207, 5208",
               first_end, min_sp, max_sp);
    end
    n_checks++;
    if (mid_cnt !== 10 || end_cnt !== 10) begin
      n_fail++;
      $display("FAIL def_strobe_count: mid %0d end %0d expected 10 10", mid_cnt, end_cnt);
    end
    n_checks++;
    if (fd_cnt !== 1 || fd_pos !== 52079) begin
      n_fail++;
      $display("FAIL def_frame_done: cnt %0d pos %0d expected 1 at 52079", fd_cnt, fd_pos);
    end
    // After frame_done with run still high: HOLD, busy, no further strobes.
    n_checks++;
    if (last_strobe !== 52079 || busy_end !== 1'b1) begin
      n_fail++;
      $display("FAIL def_hold: last strobe %0d busy %b expected 52079 1", last_strobe, busy_end);
    end
`ifndef UART_BAUD_OS_EN
    n_checks++;
    if (os_cnt !== 0) begin
      n_fail++;
      $display("FAIL def_os_tick_tied: got %0d ticks expected 0", os_cnt);
    end
`endif
    bus.run = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL def_hold_exit: busy %b expected 0", bus.busy);
    end
  endtask

  task automatic test_load16();
    load_div(16);
    bus.run = 1'b1;
    observe(170, -1, -1);
    n_checks++;
    if (first_mid !== 8 || first_end !== 15) begin
      n_fail++;
      $display("FAIL l16_first: mid %0d end %0d expected 8 15", first_mid, first_end);
    end
    n_checks++;
    if (min_sp !== 16 || max_sp !== 16 || end_cnt !== 10) begin
      n_fail++;
      $display("FAIL l16_period: sp %0d..%0d ends %0d expected 16 16 10", min_sp, max_sp, end_cnt);
    end
    for (int j = 0; j < 10; j++) begin
      n_checks++;
      if (idx_at_end[j] !== j) begin
        n_fail++;
        $display("FAIL l16_bit_idx[%0d]: got %0d expected %0d", j, idx_at_end[j], j);
      end
    end
    n_checks++;
    if (fd_pos !== 159 || err_cnt !== 0) begin
      n_fail++;
      $display("FAIL l16_done: fd %0d err %0d expected 159 0", fd_pos, err_cnt);
    end
    go_idle();
  endtask

  task automatic test_clamp();
    // Load and run in the same cycle; 2 clamps to 4.
    bus.div_load = 1'b1;
    bus.baud_div = 16'd2;
    bus.run = 1'b1;
    observe(50, -1, -1);
    n_checks++;
    if (first_mid !== 2 || first_end !== 3) begin
      n_fail++;
      $display("FAIL clamp_first: mid %0d end %0d expected 2 3", first_mid, first_end);
    end
    n_checks++;
    if (min_sp !== 4 || max_sp !== 4 || both_cnt !== 0) begin
      n_fail++;
      $display("FAIL clamp_period: sp %0d..%0d overlap %0d expected 4 4 0", min_sp, max_sp,
               both_cnt);
    end
    n_checks++;
    if (fd_pos !== 39 || mid_cnt !== 10) begin
      n_fail++;
      $display("FAIL clamp_done: fd %0d mids %0d expected 39 10", fd_pos, mid_cnt);
    end
    go_idle();
  endtask

  task automatic test_div_err();
    load_div(16);
    bus.run = 1'b1;
    observe(170, -1, 20);
    n_checks++;
    if (err_cnt !== 1 || err_pos !== 21) begin
      n_fail++;
      $display("FAIL err_pulse: cnt %0d pos %0d expected 1 at 21", err_cnt, err_pos);
    end
    n_checks++;
    if (min_sp !== 16 || max_sp !== 16 || fd_pos !== 159) begin
      n_fail++;
      $display("FAIL err_div_kept: sp %0d..%0d fd %0d expected 16 16 159", min_sp, max_sp, fd_pos);
    end
    go_idle();
  endtask

  task automatic test_abort();
    // Divisor is still 16; drop run at bit 5, cnt 10 (k = 90).
    bus.run = 1'b1;
    observe(120, 90, -1);
    n_checks++;
    if (drop_idx !== 5) begin
      n_fail++;
      $display("FAIL abort_idx: got %0d expected 5", drop_idx);
    end
    n_checks++;
    if (fd_cnt !== 0 || end_cnt !== 5 || mid_cnt !== 6 || last_strobe !== 88) begin
      n_fail++;
      $display("FAIL abort_strobes: fd %0d end %0d mid %0d last %0d expected 0 5 6 88",
               fd_cnt, end_cnt, mid_cnt, last_strobe);
    end
    n_checks++;
    if (idle_pos !== 91 || busy_end !== 1'b0 || idx_end !== 4'd0) begin
      n_fail++;
      $display("FAIL abort_idle: idle at %0d busy %b idx %0d expected 91 0 0",
               idle_pos, busy_end, idx_end);
    end
  endtask

`ifdef UART_BAUD_OS_EN
  task automatic test_oversample();
    load_div(160);
    bus.run = 1'b1;
    observe(1605, -1, -1);
    n_checks++;
    if (os_cnt !== 160 || os_first !== 9) begin
      n_fail++;
      $display("FAIL os_count: got %0d first %0d expected 160 first 9", os_cnt, os_first);
    end
    n_checks++;
    if (os_min !== 10 || os_max !== 10) begin
      n_fail++;
      $display("FAIL os_spacing: got %0d..%0d expected 10", os_min, os_max);
    end
    go_idle();
  endtask
`endif

  task automatic test_reset_mid_frame();
    bus.run = 1'b1;
    observe(50, -1, -1);
    rst_n = 1'b0;
    bus.run = 1'b0;
    #1;
    n_checks++;
    if ({bus.busy, bus.bit_mid, bus.bit_end, bus.frame_done, bus.div_err, bus.os_tick} !== 6'b0
        || bus.bit_idx !== 4'd0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got %b idx %0d expected 000000 idx 0",
               {bus.busy, bus.bit_mid, bus.bit_end, bus.frame_done, bus.div_err, bus.os_tick},
               bus.bit_idx);
    end
    @(negedge clk);
    rst_n = 1'b1;
    observe(30, -1, -1);
    n_checks++;
    if (mid_cnt + end_cnt + fd_cnt + os_cnt !== 0 || busy_end !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_quiet: strobes %0d busy %b expected 0 0",
               mid_cnt + end_cnt + fd_cnt + os_cnt, busy_end);
    end
    // Divisor must be back at the 5208 default.
    bus.run = 1'b1;
    observe(2610, -1, -1);
    n_checks++;
    if (first_mid !== 2604) begin
      n_fail++;
      $display("FAIL rst_mid_default_div: first mid %0d expected 2604", first_mid);
    end
    go_idle();
  endtask

  initial begin
    bus.run = 1'b0;
    bus.div_load = 1'b0;
    bus.baud_div = '0;
    test_reset();
    test_default_frame();
    test_load16();
    test_clamp();
    test_div_err();
    test_abort();
`ifdef UART_BAUD_OS_EN
    test_oversample();
`endif
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
